rsa_modexp_engine: RTL and testbench
====================================

RSA_MODEXP_ENGINE -- requirements
Module: rsa_modexp_engine

Interface
REQ-001 Parameter WordSize, default 32, width of base, modulus and result; legal range 4..2048.
REQ-002 Parameter ExpSize, default WordSize, width of the exponent; legal range 1..2048.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-005 go  input  1  start request, sampled on a rising edge while ready=1.
REQ-006 abort  input  1  synchronous cancel of the operation in progress.
REQ-007 ct  input  1  mode select, sampled with go: 1 = constant-time (all ExpSize bits), 0 = early exit.
REQ-008 input_text  input  WordSize  base operand.
REQ-009 key  input  ExpSize  exponent.
REQ-010 mod  input  WordSize  modulus.
REQ-011 output_text  output  WordSize  result input_text^key mod mod.
REQ-012 ready  output  1  engine idle and able to accept go.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  operand error flag, valid while done=1.

Function
REQ-015 States: IDLE, MUL, NEXT, DONE; ready=1 only in IDLE.
REQ-016 Accept: go=1 in IDLE latches input_text, key, mod and ct, and sets acc=1, sq=input_text, bit counter=ExpSize.
REQ-017 Operand check at accept: if mod<2 or input_text>=mod, the block goes to DONE with err=1, and output_text is set to 0 on the same edge.
REQ-018 go while not in IDLE is ignored; latched operands are unaffected by input changes after accept.
REQ-019 MUL runs two interleaved shift-add modular multipliers in parallel: P1=acc*sq mod m and P2=sq*sq mod m.
REQ-020 Each multiplier processes one multiplier bit per cycle, MSB first, for exactly WordSize cycles.
REQ-021 Multiplier step: r <- 2r + (bit ? a : 0), followed by conditional subtraction of m at most twice; the intermediate width is WordSize+2 and no truncation is permitted.
REQ-022 NEXT, one cycle:
- if the exponent LSB is 1, acc <- P1;
- sq <- P2;
- exponent shifts right by 1;
- counter decrements.
REQ-023 Exit from NEXT:
- counter reaches 0: go to DONE;
- ct=0 and the shifted exponent is 0: go to DONE;
- otherwise: return to MUL.
REQ-024 Latency with ct=1: done=1 in the cycle beginning ExpSize*(WordSize+1) rising edges after the accepting edge; independent of operand values.
REQ-025 Latency with ct=0: n*(WordSize+1) edges, where n is the bit position of the highest set key bit plus 1; key=0 gives n=1.
REQ-026 key=0 with valid operands: output_text=1.
REQ-027 DONE lasts one cycle: done=1, and output_text is loaded with acc (or 0 on error) on the edge entering DONE; the next state is IDLE.
REQ-028 output_text and err hold their values until the next accepting edge.
REQ-029 abort=1 in MUL or NEXT: return to IDLE on that edge, with no done pulse and output_text/err unchanged.
REQ-030 abort in IDLE or DONE has no effect.
REQ-031 abort and go asserted together in IDLE: go is accepted.

Reset
REQ-032 reset=0 at any time, including mid-operation, gives:
- state = IDLE;
- output_text = 0, done = 0, err = 0, ready = 1;
- all internal registers = 0.
REQ-033 After reset deassertion, go is accepted on the first rising edge.

Verification (WordSize=8, ExpSize=8)
REQ-034 Encrypt: input_text=88, key=7, mod=187, ct=1 -> output_text=11, err=0, done exactly 72 edges after accept.
REQ-035 Decrypt, ct=0: input_text=11, key=23, mod=187 -> output_text=88, done 45 edges after accept.
REQ-036 Same encrypt with ct=0 -> output_text=11, done 27 edges after accept; input_text=4, key=13, mod=251, ct=1 -> output_text=249.
REQ-037 Error cases:
- mod=1 -> done and err=1 on the edge after accept, output_text=0;
- input_text=200, mod=187 -> same response;
- key=0, input_text=5, mod=187 -> output_text=1, err=0.
REQ-038 Abort and busy-go: abort at edge 30 of a running operation -> no done, ready=1 next cycle, and the previous output_text is retained; go pulses while busy are ignored.
REQ-039 Reset mid-run: reset=0 at edge 40 -> all outputs are at their reset values immediately; a new operation after release completes correctly.

Source files
------------

// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine: right-to-left binary modular exponentiation.
// Each exponent bit costs WordSize cycles in MUL plus one cycle in NEXT.
// During MUL, two shift-add modular multipliers run in parallel:
//    P1 = acc*sq mod m
//    P2 = sq*sq mod m
// Both multipliers walk the bits of sq MSB first.
module rsa_modexp_engine #(
   parameter int WordSize = 32,
   parameter int ExpSize  = WordSize
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                go,
   input  logic                abort,
   input  logic                ct,
   input  logic [WordSize-1:0] input_text,
   input  logic [ExpSize-1:0]  key,
   input  logic [WordSize-1:0] mod,
   output logic [WordSize-1:0] output_text,
   output logic                ready,
   output logic                done,
   output logic                err
);

   localparam int IdxW = (WordSize > 1) ? $clog2(WordSize) : 1;
   localparam int CntW = $clog2(ExpSize + 1);

   typedef enum logic [1:0] {IDLE, MUL, NEXT, DONE} state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [WordSize-1:0] r_acc;
   logic [WordSize-1:0] r_sq;
   logic [WordSize-1:0] r_mod;
   logic [ExpSize-1:0]  r_exp;
   logic                r_ct;
   logic [CntW-1:0]     r_cnt;
   logic [IdxW-1:0]     r_idx;
   logic [WordSize-1:0] r_p1;
   logic [WordSize-1:0] r_p2;
   logic [WordSize-1:0] r_outText;
   logic                r_err;

   logic                w_opErr;
   logic                w_bit;
   logic [WordSize-1:0] w_p1Step;
   logic [WordSize-1:0] w_p2Step;
   logic [ExpSize-1:0]  w_expNext;
   logic [CntW-1:0]     w_cntNext;
   logic [WordSize-1:0] w_accNext;
   logic                w_finish;

   // One multiplier step. Computes 2r + (b ? a : 0) in WordSize+2 bits,
   // then subtracts m at most twice. Since r < m and a < m, the sum is
   // below 3m, so two subtractions always bring it back into [0, m).
   function automatic logic [WordSize-1:0] mulStep(
      input logic [WordSize-1:0] r,
      input logic [WordSize-1:0] a,
      input logic                b,
      input logic [WordSize-1:0] m
   );
      logic [WordSize+1:0] t;
      logic [WordSize+1:0] mw;
      mw = {2'b00, m};
      t  = {1'b0, r, 1'b0} + (b ? {2'b00, a} : {(WordSize+2){1'b0}});
      if (t >= mw) t = t - mw;
      if (t >= mw) t = t - mw;
      return t[WordSize-1:0];
   endfunction

   assign w_opErr   = (mod < WordSize'(2)) || (input_text >= mod);
   assign w_bit     = r_sq[r_idx];
   assign w_p1Step  = mulStep(r_p1, r_acc, w_bit, r_mod);
   assign w_p2Step  = mulStep(r_p2, r_sq, w_bit, r_mod);
   assign w_expNext = r_exp >> 1;
   assign w_cntNext = r_cnt - CntW'(1);
   assign w_accNext = r_exp[0] ? r_p1 : r_acc;
   assign w_finish  = (w_cntNext == '0) || (!r_ct && (w_expNext == '0));

   assign output_text = r_outText;
   assign err         = r_err;
   assign ready       = (r_state == IDLE);
   assign done        = (r_state == DONE);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   // Next-state logic. Abort only matters while an operation is running.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: if (go) w_nextState = w_opErr ? DONE : MUL;
         MUL: begin
            if (abort)              w_nextState = IDLE;
            else if (r_idx == '0)   w_nextState = NEXT;
         end
         NEXT: begin
            if (abort)              w_nextState = IDLE;
            else if (w_finish)      w_nextState = DONE;
            else                    w_nextState = MUL;
         end
         DONE: w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Datapath. This covers the operand latch, the multiplier steps, the
   // per-bit exponent update and the result register. An aborted cycle
   // changes nothing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc     <= '0;
         r_sq      <= '0;
         r_mod     <= '0;
         r_exp     <= '0;
         r_ct      <= 1'b0;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_p1      <= '0;
         r_p2      <= '0;
         r_outText <= '0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (go) begin
                  r_acc <= WordSize'(1);
                  r_sq  <= input_text;
                  r_mod <= mod;
                  r_exp <= key;
                  r_ct  <= ct;
                  r_cnt <= CntW'(ExpSize);
                  r_idx <= IdxW'(WordSize - 1);
                  r_p1  <= '0;
                  r_p2  <= '0;
                  r_err <= w_opErr;
                  if (w_opErr) r_outText <= '0;
               end
            end
            MUL: begin
               if (!abort) begin
                  r_p1  <= w_p1Step;
                  r_p2  <= w_p2Step;
                  r_idx <= r_idx - IdxW'(1);
               end
            end
            NEXT: begin
               if (!abort) begin
                  r_acc <= w_accNext;
                  r_sq  <= r_p2;
                  r_exp <= w_expNext;
                  r_cnt <= w_cntNext;
                  r_idx <= IdxW'(WordSize - 1);
                  r_p1  <= '0;
                  r_p2  <= '0;
                  if (w_finish) r_outText <= w_accNext;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Scoreboard bench for rsa_modexp_engine with WordSize=8 and ExpSize=8.
// The stimulus pushes the expected result and latency for each operation.
// A monitor pops and compares each entry on every done pulse.
module tb_rsa_modexp_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       go = 1'b0;
   logic       abort = 1'b0;
   logic       ct = 1'b0;
   logic [7:0] input_text = '0;
   logic [7:0] key = '0;
   logic [7:0] mod = '0;
   logic [7:0] output_text;
   logic       ready;
   logic       done;
   logic       err;

   int cycleCount = 0;
   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      string      name;
      logic [7:0] outText;
      logic       errFlag;
      int         acceptCycle;
      int         latency;
   } exp_t;

   exp_t sbQ[$];

   rsa_modexp_engine #(.WordSize(8), .ExpSize(8)) dut (
      .clk(clk),
      .reset(reset),
      .go(go),
      .abort(abort),
      .ct(ct),
      .input_text(input_text),
      .key(key),
      .mod(mod),
      .output_text(output_text),
      .ready(ready),
      .done(done),
      .err(err)
   );

   // Free-running clock and edge counter used for latency measurement.
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Compares one value and updates the pass and check counters.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checkCount++;
      if (act === req) passCount++;
      else $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   // Monitor. Every done pulse must match the oldest scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && done) begin
            if (sbQ.size() == 0) begin
               checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sbQ.pop_front();
               checkOutput({e.name, "_out"}, {24'd0, output_text}, {24'd0, e.outText});
               checkOutput({e.name, "_err"}, {31'd0, err}, {31'd0, e.errFlag});
               checkOutput({e.name, "_latency"}, cycleCount - e.acceptCycle, e.latency);
            end
         end
      end
   end

   // Waits for ready, then presents one go pulse. Optionally releases reset
   // on the same cycle and records the expected response.
   task automatic applyStimulus(
      input string      name,
      input logic [7:0] t,
      input logic [7:0] k,
      input logic [7:0] m,
      input logic       c,
      input logic       ab,
      input logic       relRst,
      input logic       track,
      input logic [7:0] eo,
      input logic       ee,
      input int         el,
      output int        accCycle
   );
      int guard;
      guard = 0;
      @(negedge clk);
      if (relRst) reset = 1'b1;
      while (!ready && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (!ready) checkOutput({name, "_ready_timeout"}, 32'd0, 32'd1);
      input_text = t;
      key        = k;
      mod        = m;
      ct         = c;
      abort      = ab;
      go         = 1'b1;
      @(posedge clk);
      #1;
      go       = 1'b0;
      abort    = 1'b0;
      accCycle = cycleCount;
      if (track) sbQ.push_back('{name, eo, ee, accCycle, el});
   endtask

   // Waits until the monitor has consumed every outstanding expectation.
   task automatic waitDrain();
      int guard;
      guard = 0;
      while (sbQ.size() != 0 && guard < 2000) begin
         @(posedge clk);
         guard++;
      end
      if (sbQ.size() != 0) checkOutput("drain_timeout", sbQ.size(), 32'd0);
   endtask

   // Hard stop in case some part of the bench stops making progress.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence.
   initial begin
      int acc;
      #12;
      checkOutput("rst_out", {24'd0, output_text}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_err", {31'd0, err}, 32'd0);
      checkOutput("rst_ready", {31'd0, ready}, 32'd1);

      applyStimulus("enc_ct", 8'd88, 8'd7, 8'd187, 1'b1, 1'b0, 1'b1, 1'b1, 8'd11, 1'b0, 72, acc);
      waitDrain();

      // Go pulses while busy, with different operands, must be ignored.
      applyStimulus("dec_busy", 8'd11, 8'd23, 8'd187, 1'b0, 1'b0, 1'b0, 1'b1, 8'd88, 1'b0, 45, acc);
      repeat (5) @(posedge clk);
      #1;
      input_text = 8'd3; key = 8'd5; mod = 8'd200; go = 1'b1;
      @(posedge clk);
      #1 go = 1'b0;
      repeat (14) @(posedge clk);
      #1 go = 1'b1;
      @(posedge clk);
      #1 go = 1'b0;
      waitDrain();

      applyStimulus("enc_early", 8'd88, 8'd7, 8'd187, 1'b0, 1'b0, 1'b0, 1'b1, 8'd11, 1'b0, 27, acc);
      waitDrain();
      applyStimulus("pow4_13", 8'd4, 8'd13, 8'd251, 1'b1, 1'b0, 1'b0, 1'b1, 8'd249, 1'b0, 72, acc);
      waitDrain();
      applyStimulus("err_mod1", 8'd0, 8'd7, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 0, acc);
      waitDrain();
      applyStimulus("err_big", 8'd200, 8'd7, 8'd187, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 0, acc);
      waitDrain();
      // Abort asserted together with go in IDLE: go wins.
      applyStimulus("key0_early", 8'd5, 8'd0, 8'd187, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 9, acc);
      waitDrain();
      applyStimulus("key0_ct", 8'd5, 8'd0, 8'd187, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 72, acc);
      waitDrain();

      // Abort at edge 30 of a run. No done pulse, and the old result is kept.
      applyStimulus("abort_run", 8'd88, 8'd7, 8'd187, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 0, acc);
      repeat (29) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      checkOutput("abort_ready", {31'd0, ready}, 32'd1);
      checkOutput("abort_done", {31'd0, done}, 32'd0);
      checkOutput("abort_keep_out", {24'd0, output_text}, 32'd1);
      repeat (80) @(posedge clk);
      #1;
      checkOutput("abort_still_idle", {31'd0, ready}, 32'd1);

      // Reset in the middle of a run.
      applyStimulus("rst_run", 8'd88, 8'd7, 8'd187, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 0, acc);
      repeat (39) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("midrst_out", {24'd0, output_text}, 32'd0);
      checkOutput("midrst_done", {31'd0, done}, 32'd0);
      checkOutput("midrst_err", {31'd0, err}, 32'd0);
      checkOutput("midrst_ready", {31'd0, ready}, 32'd1);
      applyStimulus("after_rst", 8'd4, 8'd13, 8'd251, 1'b1, 1'b0, 1'b1, 1'b1, 8'd249, 1'b0, 72, acc);
      waitDrain();

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
